// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: arbiter state encoding
// and the clog2 helper used for index and counter widths.
package fifo_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr,
// wrapping, found through a double-width masked copy.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  localparam int DW2 = 2 * NREQ;

  logic [DW2-1:0] dbl;
  logic [DW2-1:0] keep;
  logic [DW2-1:0] masked;

  assign dbl    = {req_i, req_i};
  assign keep   = ~((DW2'(1) << ptr_i) - DW2'(1));
  assign masked = dbl & keep;

  // lowest surviving bit of the doubled vector, folded mod NREQ
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int i = 0; i < DW2; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx_o = IW'(i % NREQ);
      end
    end
    any_o = found;
    gnt_o = found ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter in front of the
// write port of a dual-clock FIFO.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16,
  localparam int IW = clog2(NREQ)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wr_data,
  output logic                  fifo_wr_inc,
  input  logic                  fifo_wr_full,
  output logic [NREQ-1:0]       grant,
  output logic [IW-1:0]         grant_id
);

  localparam int CW =
    (MAX_BURST > 0) ? clog2(MAX_BURST + 1) : 1;

  logic            state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_nxt;
  logic            accept;
  logic            cap_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign pick_nxt = (pick_idx == IW'(NREQ - 1))
                  ? '0 : pick_idx + IW'(1);

  assign accept = (state_q == ST_BURST)
                & req_valid[gid_q]
                & ~fifo_wr_full;

  assign cap_hit = (MAX_BURST != 0)
                && (cnt_q == CW'(MAX_BURST - 1));

  assign fifo_wr_inc = accept;
  assign req_ready   = grant_q & {NREQ{accept}};
  assign grant       = grant_q;
  assign grant_id    = gid_q;

  // owner's data to the FIFO; quiet bus while nobody owns it
  always_comb begin
    fifo_wr_data = '0;
    if (|grant_q) fifo_wr_data = req_data[gid_q*DSIZE +: DSIZE];
  end

  // arbitrate in IDLE, hold the port until last or the beat cap
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BURST;
          grant_d = pick_gnt;
          gid_d   = pick_idx;
          ptr_d   = pick_nxt;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (req_last[gid_q] | cap_hit) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    valid;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]    last;
  logic [NR-1:0]    ready;
  logic [DW-1:0]    wdata;
  logic             inc;
  logic             full;
  logic [NR-1:0]    grant;
  logic [1:0]       gid;

  beat_t drv[NR][$];
  beat_t sb[NR][$];

  int tests = 0;
  int fails = 0;
  int pv[NR];
  int pfull = 0;
  int hold_off[NR];
  bit force_full = 1'b0;

  fifo_wr_arbiter #(
    .NREQ      (NR),
    .DSIZE     (DW),
    .MAX_BURST (MAXB)
  ) dut (
    .wr_clk       (clk),
    .wr_rst_n     (rst_n),
    .req_valid    (valid),
    .req_data     (data),
    .req_last     (last),
    .req_ready    (ready),
    .fifo_wr_data (wdata),
    .fifo_wr_inc  (inc),
    .fifo_wr_full (full),
    .grant        (grant),
    .grant_id     (gid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic add_burst(input int r, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = DW'($urandom);
      b.l = (k == n - 1);
      drv[r].push_back(b);
      sb[r].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (drv[i].size() != 0) begin
        data[i*DW +: DW] = drv[i][0].d;
        last[i] = drv[i][0].l;
        valid[i] = ($urandom_range(0, 99) < pv[i]);
      end else begin
        data[i*DW +: DW] = '0;
        last[i] = 1'b0;
        valid[i] = 1'b0;
      end
      if (hold_off[i] > 0) begin
        valid[i] = 1'b0;
        hold_off[i]--;
      end
    end
    full = force_full | ($urandom_range(0, 99) < pfull);
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (valid[i] && ready[i] && drv[i].size() != 0)
        void'(drv[i].pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += drv[i].size();
    return s;
  endfunction

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (pending() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_done", pending(), 0);
    repeat (2) step();
  endtask

  task automatic wait_size(input int r, input int sz);
    int n;
    n = 0;
    while (drv[r].size() != sz && n < 100) begin
      step();
      n++;
    end
    chk("wait_beats", drv[r].size(), sz);
  endtask

  // monitor: behavioural owner/pointer model, scoreboard pops
  initial begin
    int own;
    int gm;
    int ptr;
    int cnt;
    bit acc;
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    beat_t b;
    own = -1;
    gm  = 0;
    ptr = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        own = -1;
        gm  = 0;
        ptr = 0;
        cnt = 0;
        chk("rst_grant", grant, 0);
        chk("rst_gid", gid, 0);
        chk("rst_ready", ready, 0);
        chk("rst_inc", inc, 0);
        chk("rst_data", wdata, 0);
      end else begin
        eg = '0;
        if (own >= 0) eg[own] = 1'b1;
        chk("grant", grant, eg);
        chk("grant_id", gid, gm);
        acc = (own >= 0) && valid[own] && !full;
        er = '0;
        if (acc) er[own] = 1'b1;
        chk("ready", ready, er);
        chk("wr_inc", inc, acc);
        if (own < 0) begin
          chk("idle_data", wdata, 0);
          for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (own < 0 && valid[j]) begin
              own = j;
              gm  = j;
              ptr = (j + 1) % NR;
              cnt = 0;
            end
          end
        end else if (acc) begin
          if (sb[own].size() == 0) begin
            chk("sb_underflow", 1, 0);
            own = -1;
          end else begin
            b = sb[own].pop_front();
            chk("wr_data", wdata, b.d);
            if (b.l || cnt + 1 == MAXB) own = -1;
            else cnt++;
          end
        end
      end
    end
  end

  initial begin
    valid = '0;
    data  = '0;
    last  = '0;
    full  = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 100;
      hold_off[i] = 0;
    end
    repeat (3) step();
    rst_n = 1'b1;

    // single requester, three beats
    add_burst(2, 3);
    drain(100);

    // fairness: single-beat bursts on every requester
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NR; i++) add_burst(i, 1);
    drain(200);

    // backpressure for 5 cycles on beat 2
    add_burst(0, 4);
    wait_size(0, 3);
    force_full = 1'b1;
    full = 1'b1;
    repeat (5) step();
    force_full = 1'b0;
    full = 1'b0;
    drain(100);

    // beat cap splits a 6-beat burst around req 3
    add_burst(1, 6);
    add_burst(3, 1);
    drain(100);

    // owner stalls 3 cycles while req 0 waits
    add_burst(2, 4);
    add_burst(0, 1);
    wait_size(2, 3);
    hold_off[2] = 3;
    drive();
    drain(100);

    // async reset in the middle of a burst
    add_burst(3, 5);
    add_burst(1, 2);
    wait_size(3, 3);
    add_burst(2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_inc", inc, 0);
    chk("async_ready", ready, 0);
    repeat (2) step();
    rst_n = 1'b1;
    drain(100);

    // randomized traffic with stalls and backpressure
    for (int i = 0; i < NR; i++)
      pv[i] = $urandom_range(50, 100);
    pfull = 25;
    for (int k = 0; k < 40; k++)
      add_burst($urandom_range(0, NR - 1),
                $urandom_range(1, 7));
    drain(3000);
    pfull = 0;

    for (int i = 0; i < NR; i++)
      chk("sb_left", sb[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
